seven_seg_scan: RTL and testbench

//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.

---
 rtl/seven_seg_scan_if.sv | 32 +++
 rtl/seven_seg_scan.sv | 112 +++++++++++
 tb/tb_seven_seg_scan.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_if.sv
// ----------------------------------------------------------------------------
// seven_seg_scan_if
//   Bundles the digit inputs and the display pin outputs of seven_seg_scan.
//   master : timer-datapath side. It drives the BCD digits and observes the pins.
//   slave  : the scan driver. It consumes the digits and drives the pins.
//   Signals:
//     digit0..digit3 : BCD digits. digit0 is the rightmost digit.
//     anode          : active-low digit enables. Bit k drives digit k.
//     segment        : active-low cathodes, ordered {g,f,e,d,c,b,a}.
//     dp             : active-low decimal point.
//     frame          : 1-clk pulse on the cycle the shadow register loads.
// ----------------------------------------------------------------------------
interface seven_seg_scan_if;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] anode;
    logic [6:0] segment;
    logic       dp;
    logic       frame;

    modport master (
        output digit0, digit1, digit2, digit3,
        input  anode, segment, dp, frame
    );

    modport slave (
        input  digit0, digit1, digit2, digit3,
        output anode, segment, dp, frame
    );
endinterface

// File: rtl/seven_seg_scan.sv
// ----------------------------------------------------------------------------
// seven_seg_scan
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   - Snapshots the four BCD digits once per refresh frame, so a frame never
//     mixes old and new digits.
//   - Scans one digit per slot of SCAN_DIV clocks.
//   - Keeps the display dark for the first BLANK_CYCLES clocks of each slot.
//     This guard interval suppresses ghosting between digits.
//   - Can blank leading zeros above the decimal-point digit.
//   Ports:
//     clk   : system clock
//     reset : asynchronous, active-low reset
//     bus   : seven_seg_scan_if.slave. It carries digit0..3 in, and
//             anode/segment/dp/frame out. All outputs are registered.
// ----------------------------------------------------------------------------
module seven_seg_scan #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 4,
    parameter int DP_POS       = 2,
    parameter int LZ_BLANK     = 1
) (
    input  logic                clk,
    input  logic                reset,
    seven_seg_scan_if.slave     bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    sel;
    logic [15:0]   shadow;

    logic          tick;
    logic [3:0]    cur_digit;
    logic          lz_blank;
    logic [3:0]    next_anode;
    logic [6:0]    next_segment;
    logic          next_dp;

    // Active-low decode. Non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign tick      = (cnt == CW'(SCAN_DIV - 1));
    assign cur_digit = shadow[{sel, 2'b00} +: 4];

    // Digit sel is a leading zero when it lies above the decimal point and
    // every digit from sel up to the leftmost one is zero.
    always_comb begin
        // NOTE: every variable written in this block gets a default first, so no latch is inferred.
        lz_blank = 1'b0;
        if (LZ_BLANK != 0 && sel != 2'd0 && int'(sel) > DP_POS) begin
            lz_blank = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (k >= int'(sel) && shadow[k*4 +: 4] != 4'd0) begin
                    lz_blank = 1'b0;
                end
            end
        end
    end

    // Pin values for the current (pre-edge) cnt/sel/shadow. They are
    // registered below, so the pins lag the scan state by one clock.
    always_comb begin
        next_anode   = 4'b1111;
        next_segment = 7'b1111111;
        next_dp      = 1'b1;
        if (cnt >= CW'(BLANK_CYCLES) && !lz_blank) begin
            next_anode   = ~(4'b0001 << sel);
            next_segment = decode(cur_digit);
            next_dp      = (int'(sel) == DP_POS) ? 1'b0 : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            sel         <= 2'd0;
            // NOTE: the shadow register is reset because the first frame after
            // reset must display zeros, not power-up garbage.
            shadow      <= 16'h0000;
            bus.anode   <= 4'b1111;
            bus.segment <= 7'b1111111;
            bus.dp      <= 1'b1;
            bus.frame   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register in this block
            // see pre-edge values, which the one-clock output latency relies on.
            cnt         <= tick ? '0 : cnt + 1'b1;
            sel         <= tick ? sel + 2'd1 : sel;
            bus.anode   <= next_anode;
            bus.segment <= next_segment;
            bus.dp      <= next_dp;
            bus.frame   <= tick && (sel == 2'd3);
            if (tick && sel == 2'd3) begin
                shadow <= {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_scan
//   Directed bench for seven_seg_scan with these parameters:
//     SCAN_DIV=8, BLANK_CYCLES=2, DP_POS=2, LZ_BLANK=1.
//   Timing reference: the frame pulse is offset 0.
//     At offset t (sampled on the falling edge), the pins show scan position
//     t-1, where position = sel*8 + cnt, using the freshly loaded shadow.
// ----------------------------------------------------------------------------
module tb_seven_seg_scan;
    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic reset = 1'b1;

    seven_seg_scan_if bus ();

    seven_seg_scan #(
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2),
        .DP_POS      (2),
        .LZ_BLANK    (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] digits;    // {digit3,digit2,digit1,digit0}
        int          offset;    // falling edges after the frame pulse
        logic [3:0]  anode;
        logic [6:0]  segment;
        logic        dp;
        bit          seg_care;  // segment is unspecified on a blanked slot
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [15:0] d, input int off, input logic [3:0] an,
                       input logic [6:0] sg, input logic p, input bit sc = 1'b1);
        vec_t v;
        v.digits = d; v.offset = off; v.anode = an; v.segment = sg; v.dp = p; v.seg_care = sc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_digits(input logic [15:0] d);
        bus.digit3 = d[15:12];
        bus.digit2 = d[11:8];
        bus.digit1 = d[7:4];
        bus.digit0 = d[3:0];
    endtask

    // Returns on the falling edge where frame is high, after the next load.
    task automatic sync_frame(input string name);
        int b = 0;
        while (bus.frame === 1'b1 && b < 4) begin step(1); b++; end
        b = 0;
        while (bus.frame !== 1'b1 && b < 80) begin step(1); b++; end
        check({name, "_frame_sync"}, 32'(bus.frame), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur_off;
        int cnt_clk;

        set_digits(16'h0000);

        // Reset with the clock stopped.
        #5 reset = 1'b0;
        #5;
        check("rst_anode",   32'(bus.anode),   32'hF);
        check("rst_segment", 32'(bus.segment), 32'h7F);
        check("rst_dp",      32'(bus.dp),      32'd1);
        check("rst_frame",   32'(bus.frame),   32'd0);
        clk_en = 1'b1;
        step(2);
        reset = 1'b1;

        // Vectors: {digits, offset, anode, segment, dp[, seg_care]}
        add(16'h5947,  1, 4'b1111, 7'b1111111, 1'b1);
        add(16'h5947,  3, 4'b1110, 7'b1111000, 1'b1);
        add(16'h5947,  9, 4'b1111, 7'b1111111, 1'b1);
        add(16'h5947, 11, 4'b1101, 7'b0011001, 1'b1);
        add(16'h5947, 19, 4'b1011, 7'b0010000, 1'b0);
        add(16'h5947, 25, 4'b1111, 7'b1111111, 1'b1);
        add(16'h5947, 27, 4'b0111, 7'b0010010, 1'b1);
        add(16'h5947, 31, 4'b0111, 7'b0010010, 1'b1);
        add(16'h0005,  3, 4'b1110, 7'b0010010, 1'b1);
        add(16'h0005, 11, 4'b1101, 7'b1000000, 1'b1);
        add(16'h0005, 19, 4'b1011, 7'b1000000, 1'b0);
        add(16'h0005, 26, 4'b1111, 7'b1111111, 1'b1);
        add(16'h0005, 27, 4'b1111, 7'b1111111, 1'b1, 1'b0);
        add(16'h0005, 31, 4'b1111, 7'b1111111, 1'b1, 1'b0);
        add(16'h12C0,  3, 4'b1110, 7'b1000000, 1'b1);
        add(16'h12C0, 11, 4'b1101, 7'b0111111, 1'b1);
        add(16'h12C0, 19, 4'b1011, 7'b0100100, 1'b0);
        add(16'h12C0, 27, 4'b0111, 7'b1111001, 1'b1);
        add(16'h0800,  3, 4'b1110, 7'b1000000, 1'b1);
        add(16'h0800, 11, 4'b1101, 7'b1000000, 1'b1);
        add(16'h0800, 19, 4'b1011, 7'b0000000, 1'b0);
        add(16'h0800, 27, 4'b1111, 7'b1111111, 1'b1, 1'b0);
        add(16'h6328,  3, 4'b1110, 7'b0000000, 1'b1);
        add(16'h6328, 11, 4'b1101, 7'b0100100, 1'b1);
        add(16'h6328, 19, 4'b1011, 7'b0110000, 1'b0);
        add(16'h6328, 27, 4'b0111, 7'b0000010, 1'b1);
        add(16'h0000,  3, 4'b1110, 7'b1000000, 1'b1);
        add(16'h0000, 11, 4'b1101, 7'b1000000, 1'b1);
        add(16'h0000, 19, 4'b1011, 7'b1000000, 1'b0);
        add(16'h0000, 27, 4'b1111, 7'b1111111, 1'b1, 1'b0);

        cur_off = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].digits != vecs[i-1].digits) begin
                set_digits(vecs[i].digits);
                sync_frame($sformatf("v%0d", i));
                cur_off = 0;
            end
            step(vecs[i].offset - cur_off);
            cur_off = vecs[i].offset;
            check($sformatf("v%0d_%h_o%0d_anode", i, vecs[i].digits, vecs[i].offset),
                  32'(bus.anode), 32'(vecs[i].anode));
            if (vecs[i].seg_care)
                check($sformatf("v%0d_%h_o%0d_segment", i, vecs[i].digits, vecs[i].offset),
                      32'(bus.segment), 32'(vecs[i].segment));
            check($sformatf("v%0d_%h_o%0d_dp", i, vecs[i].digits, vecs[i].offset),
                  32'(bus.dp), 32'(vecs[i].dp));
            check($sformatf("v%0d_%h_o%0d_frame", i, vecs[i].digits, vecs[i].offset),
                  32'(bus.frame), 32'd0);
        end

        // The frame period is exactly 32 clocks, measured over two frames.
        for (int f = 0; f < 2; f++) begin
            sync_frame("period");
            cnt_clk = 0;
            do begin step(1); cnt_clk++; end while (bus.frame !== 1'b1 && cnt_clk < 64);
            check($sformatf("frame_period_%0d", f), 32'(cnt_clk), 32'd32);
        end

        // A digit change mid-frame stays hidden until the next snapshot.
        set_digits(16'h5947);
        sync_frame("nt");
        step(5);
        check("nt_before_segment", 32'(bus.segment), 32'b1111000);
        bus.digit0 = 4'd1;
        step(1);
        check("nt_after_change_segment", 32'(bus.segment), 32'b1111000);
        step(25);
        check("nt_offset31_frame", 32'(bus.frame), 32'd0);
        sync_frame("nt2");
        step(3);
        check("nt_next_frame_anode",   32'(bus.anode),   32'b1110);
        check("nt_next_frame_segment", 32'(bus.segment), 32'b1111001);

        // Async reset at cnt=5, sel=2. The pins show the slot-2 active phase just before.
        set_digits(16'h5947);
        sync_frame("ar");
        step(21);
        check("ar_pre_anode", 32'(bus.anode), 32'b1011);
        #1 reset = 1'b0;
        #1;
        check("ar_anode",   32'(bus.anode),   32'hF);
        check("ar_segment", 32'(bus.segment), 32'h7F);
        check("ar_dp",      32'(bus.dp),      32'd1);
        check("ar_frame",   32'(bus.frame),   32'd0);
        step(2);
        check("ar_held_anode", 32'(bus.anode), 32'hF);
        reset = 1'b1;
        step(1);
        check("ar_rel_cnt0_anode", 32'(bus.anode), 32'hF);
        step(1);
        check("ar_rel_cnt1_anode", 32'(bus.anode), 32'hF);
        step(1);
        check("ar_rel_cnt2_anode",   32'(bus.anode),   32'b1110);
        check("ar_rel_cnt2_segment", 32'(bus.segment), 32'b1000000);
        check("ar_rel_cnt2_dp",      32'(bus.dp),      32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
